// File: rtl/vga_pattern_gen.sv
// VGA timing generator with a 1-bit-per-channel test pattern (bars, checker, scroll, border).
// Every registered output describes the hcount/vcount presented in the same cycle.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic       frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned BAR_LEN  = H_ACTIVE / 8;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [2:0]       bar;
    logic [CW-1:0]    run;
    logic [8:0]       frame_cnt;
    logic [1:0]       mode_q;

    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    logic [CW-1:0]    h_nxt;
    logic [CW-1:0]    v_nxt;
    logic [2:0]       bar_nxt;
    logic [CW-1:0]    run_nxt;
    logic [8:0]       fc_nxt;
    logic [1:0]       mode_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             von_nxt;
    logic             border;
    logic [2:0]       colour;
    logic [2:0]       rgb_nxt;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    // Post-tick counter values; all outputs are decoded from these.
    always_comb begin
        h_wrap     = (hcount == CW'(H_TOTAL - 1));
        v_wrap     = (vcount == CW'(V_TOTAL - 1));
        frame_wrap = h_wrap && v_wrap;
        h_nxt      = h_wrap ? '0 : hcount + CW'(1);
        v_nxt      = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount + CW'(1);
        end
        mode_nxt = frame_wrap ? mode : mode_q;
        fc_nxt   = frame_wrap ? frame_cnt + 9'd1 : frame_cnt;
    end

    // Bar index tracks hcount by run length: restart at column 0, step every BAR_LEN pixels.
    always_comb begin
        bar_nxt = bar;
        run_nxt = run + CW'(1);
        if (h_nxt == '0) begin
            bar_nxt = '0;
            run_nxt = '0;
        end else if (run == CW'(BAR_LEN - 1)) begin
            bar_nxt = bar + 3'd1;
            run_nxt = '0;
        end
    end

    always_comb begin
        hs_nxt  = (h_nxt >= CW'(HS_START) && h_nxt <= CW'(HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_nxt  = (v_nxt >= CW'(VS_START) && v_nxt <= CW'(VS_END)) ? SYNC_POL : ~SYNC_POL;
        von_nxt = (h_nxt < CW'(H_ACTIVE)) && (v_nxt < CW'(V_ACTIVE));
        border  = (h_nxt == '0) || (h_nxt == CW'(H_ACTIVE - 1)) ||
                  (v_nxt == '0) || (v_nxt == CW'(V_ACTIVE - 1));
        colour  = '0;
        case (mode_nxt)
            2'd0: colour = 3'd7 - bar_nxt;
            2'd1: colour = {3{h_nxt[5] ^ v_nxt[5]}};
            2'd2: colour = 3'd7 - (bar_nxt + fc_nxt[8:6]);
            2'd3: colour = {3{border}};
            default: colour = '0;
        endcase
        rgb_nxt = von_nxt ? colour : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            bar         <= '0;
            run         <= '0;
            frame_cnt   <= '0;
            mode_q      <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            R           <= 1'b0;
            G           <= 1'b0;
            B           <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + DIV_W'(1);
            frame_start <= 1'b0;
            if (tick) begin
                hcount      <= h_nxt;
                vcount      <= v_nxt;
                bar         <= bar_nxt;
                run         <= run_nxt;
                frame_cnt   <= fc_nxt;
                mode_q      <= mode_nxt;
                hsync       <= hs_nxt;
                vsync       <= vs_nxt;
                video_on    <= von_nxt;
                R           <= rgb_nxt[2];
                G           <= rgb_nxt[1];
                B           <= rgb_nxt[0];
                frame_start <= frame_wrap;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: a main instance with reduced timing for raster checks
// and a tiny instance for the 64-frame scroll and active-high sync checks.
module tb_vga_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       rst_s_n;
    logic [1:0] mode;
    logic [1:0] mode_s;

    logic [9:0] hc_a, vc_a, hc_b, vc_b;
    logic       hs_a, vs_a, von_a, r_a, g_a, b_a, fs_a;
    logic       hs_b, vs_b, von_b, r_b, g_b, b_b, fs_b;

    // Main instance: H 64+4+6+6=80, V 40+2+2+4=48, two clks per pixel, active-low sync.
    vga_pattern_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .R(r_a), .G(g_a), .B(b_a), .frame_start(fs_a)
    );

    // Tiny instance: H 8+1+1+1=11, V 4+1+1+1=7, a pixel per clk, active-high sync.
    vga_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_s_n), .mode(mode_s),
        .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .R(r_b), .G(g_b), .B(b_b), .frame_start(fs_b)
    );

    typedef struct {
        bit         sel;
        int         h;
        int         v;
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   fs_cnt;
    int   fs_bad;
    int   fs_s_cnt;
    int   fs_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit sel, input int h, input int v, input logic [5:0] e,
                        input string name);
        exp_t x;
        x.sel = sel; x.h = h; x.v = v; x.exp = e; x.name = name;
        sb.push_back(x);
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries unmatched, next %s", sb.size(), sb[0].name);
            sb.delete();
        end
    endtask

    // Wait for main-instance position; h < 0 matches any column.
    task automatic wait_a(input int h, input int v, input int lim);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((h < 0 || hc_a == 10'(h)) && vc_a == 10'(v)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_a: position (%0d,%0d) not reached", h, v);
        end
    endtask

    task automatic wait_fs_s(input int n, input int lim);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (fs_s_cnt - fs_base == n) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_fs_s: frame count %0d not reached, at %0d", n, fs_s_cnt - fs_base);
        end
    endtask

    initial begin
        logic       fs_a_prev;
        logic       fs_b_prev;
        int         fs_run;
        checks   = 0;
        errors   = 0;
        fs_cnt   = 0;
        fs_bad   = 0;
        fs_s_cnt = 0;
        fs_base  = 0;
        fs_a_prev = 1'b0;
        fs_b_prev = 1'b0;
        fs_run   = 0;
        rst_n    = 1'b0;
        rst_s_n  = 1'b0;
        mode     = 2'd0;
        mode_s   = 2'd2;

        fork
            // Scoreboard monitor: compare the head entry when its pixel is presented.
            forever begin
                logic [9:0] ch, cv;
                logic [5:0] act;
                @(negedge clk);
                if (sb.size() > 0) begin
                    if (sb[0].sel) begin
                        ch = hc_b; cv = vc_b; act = {hs_b, vs_b, von_b, r_b, g_b, b_b};
                    end else begin
                        ch = hc_a; cv = vc_a; act = {hs_a, vs_a, von_a, r_a, g_a, b_a};
                    end
                    if (ch == 10'(sb[0].h) && cv == 10'(sb[0].v)) begin
                        checks++;
                        if (act !== sb[0].exp) begin
                            errors++;
                            $display("FAIL %s (%0d,%0d): got hs,vs,von,rgb=%b expected %b",
                                     sb[0].name, sb[0].h, sb[0].v, act, sb[0].exp);
                        end
                        void'(sb.pop_front());
                    end
                end
            end
            // frame_start tracking: count pulses, flag wide pulses or pulses off (0,0).
            forever begin
                @(negedge clk);
                if (fs_a) begin
                    if (!fs_a_prev) fs_cnt++;
                    fs_run++;
                    if (fs_run > 1 || hc_a != 10'd0 || vc_a != 10'd0) fs_bad++;
                end else begin
                    fs_run = 0;
                end
                fs_a_prev = fs_a;
                if (fs_b && !fs_b_prev) fs_s_cnt++;
                fs_b_prev = fs_b;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hcount", int'(hc_a), 0);
        chk("rst_vcount", int'(vc_a), 0);
        chk("rst_outs", int'({hs_a, vs_a, von_a, r_a, g_a, b_a, fs_a}), 7'b1100000);

        // First tick lands CLK_DIV clks after release
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tick_latency_hold", int'(hc_a), 0);
        @(posedge clk); #1;
        chk("tick_latency_step", int'(hc_a), 1);
        chk("first_pixel", int'({von_a, r_a, g_a, b_a}), 4'b1111);

        // Asynchronous reset mid-line
        wait_a(30, 0, 1000);
        rst_n = 1'b0;
        #1;
        chk("midrst_hcount", int'(hc_a), 0);
        chk("midrst_vcount", int'(vc_a), 0);
        chk("midrst_outs", int'({hs_a, vs_a, von_a, r_a, g_a, b_a}), 6'b110000);
        @(negedge clk);
        rst_n = 1'b1;

        // Horizontal/vertical timing and colour bars (bar width 8)
        fs_base = fs_cnt;
        push(0, 0, 2,  6'b111111, "bar0_start");
        push(0, 7, 2,  6'b111111, "bar0_end");
        push(0, 8, 2,  6'b111110, "bar1_start");
        push(0, 16, 2, 6'b111101, "bar2");
        push(0, 24, 2, 6'b111100, "bar3");
        push(0, 56, 2, 6'b111000, "bar7_start");
        push(0, 63, 2, 6'b111000, "last_active_col");
        push(0, 64, 2, 6'b110000, "first_blank_col");
        push(0, 67, 2, 6'b110000, "pre_hsync");
        push(0, 68, 2, 6'b010000, "hsync_first");
        push(0, 73, 2, 6'b010000, "hsync_last");
        push(0, 74, 2, 6'b110000, "post_hsync");
        push(0, 79, 2, 6'b110000, "line_end");
        push(0, 0, 3,  6'b111111, "line_wrap");
        push(0, 0, 39, 6'b111111, "last_active_line");
        push(0, 0, 40, 6'b110000, "first_blank_line");
        push(0, 0, 41, 6'b110000, "pre_vsync");
        push(0, 0, 42, 6'b100000, "vsync_first");
        push(0, 70, 42, 6'b000000, "hsync_and_vsync");
        push(0, 5, 43, 6'b100000, "vsync_last");
        push(0, 0, 44, 6'b110000, "post_vsync");
        push(0, 0, 47, 6'b110000, "last_line");
        push(0, 0, 0,  6'b111111, "frame_wrap");
        drain(20000);
        repeat (4) @(negedge clk);
        chk("frame_start_count", fs_cnt - fs_base, 1);
        chk("frame_start_shape", fs_bad, 0);

        // Mode change mid-frame applies only from the next frame
        wait_a(-1, 20, 20000);
        mode = 2'd1;
        push(0, 8, 30,  6'b111110, "still_bars_b1");
        push(0, 40, 30, 6'b111010, "still_bars_b5");
        push(0, 31, 0,  6'b111000, "checker_31_0");
        push(0, 32, 0,  6'b111111, "checker_32_0");
        push(0, 0, 32,  6'b111111, "checker_0_32");
        push(0, 32, 32, 6'b111000, "checker_32_32");
        push(0, 40, 39, 6'b111000, "checker_40_39");
        drain(20000);

        // Border pattern
        wait_a(-1, 44, 20000);
        mode = 2'd3;
        push(0, 0, 0,   6'b111111, "border_origin");
        push(0, 10, 0,  6'b111111, "border_top");
        push(0, 0, 5,   6'b111111, "border_left");
        push(0, 1, 5,   6'b111000, "border_inside_l");
        push(0, 62, 5,  6'b111000, "border_inside_r");
        push(0, 63, 5,  6'b111111, "border_right");
        push(0, 32, 20, 6'b111000, "border_centre");
        push(0, 10, 39, 6'b111111, "border_bottom");
        push(0, 64, 39, 6'b110000, "border_blank");
        drain(20000);
        repeat (4) @(negedge clk);
        chk("frame_start_shape_end", fs_bad, 0);

        // Scrolling bars on the tiny instance (bar width 1)
        fs_base = fs_s_cnt;
        @(negedge clk);
        rst_s_n = 1'b1;
        wait_fs_s(63, 8000);
        push(1, 0, 1, 6'b001111, "scroll63_bar0");
        push(1, 5, 1, 6'b001010, "scroll63_bar5");
        drain(200);
        wait_fs_s(64, 200);
        push(1, 0, 1,  6'b001110, "scroll64_bar0");
        push(1, 1, 1,  6'b001101, "scroll64_bar1");
        push(1, 9, 1,  6'b100000, "hsync_high_pol");
        push(1, 10, 1, 6'b000000, "hsync_release");
        push(1, 7, 2,  6'b001111, "scroll64_bar7");
        push(1, 0, 5,  6'b010000, "vsync_high_pol");
        push(1, 0, 6,  6'b000000, "vsync_release");
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
